// File: rtl/spare_validity_checker_seq_if.sv
// Bus bundle between the repair-solution selector and the spare validity checker.
interface spare_validity_checker_seq_if #(
    parameter int unsigned N_PIVOT = 8,
    parameter int unsigned DSSS_W  = 8,
    parameter int unsigned RLSS_W  = 4
);
    localparam int unsigned CNT_W = $clog2(N_PIVOT + 1);

    logic                   start;
    logic [1:0]             mode;
    logic [DSSS_W-1:0]      DSSS;
    logic [RLSS_W-1:0]      RLSS;
    logic [7:0]             spare_avail;
    logic [2*N_PIVOT-1:0]   bank_addr;
    logic [3*N_PIVOT-1:0]   must_flag;

    logic                   busy;
    logic                   done;
    logic                   signal_valid;
    logic [7:0]             unused_spare;
    logic [N_PIVOT-1:0]     uncover_must_pivot;
    logic [CNT_W-1:0]       uncover_count;

    modport master (
        output start, mode, DSSS, RLSS, spare_avail, bank_addr, must_flag,
        input  busy, done, signal_valid, unused_spare, uncover_must_pivot, uncover_count
    );

    modport slave (
        input  start, mode, DSSS, RLSS, spare_avail, bank_addr, must_flag,
        output busy, done, signal_valid, unused_spare, uncover_must_pivot, uncover_count
    );
endinterface

// File: rtl/spare_validity_checker_seq.sv
// Sequential BIRA signal validity check: popcount check, then one must-repair
// pivot per cycle matched (and optionally allocated) against free spares.
module spare_validity_checker_seq #(
    parameter int unsigned N_PIVOT   = 8,
    parameter int unsigned DSSS_W    = 8,
    parameter int unsigned RLSS_W    = 4,
    parameter int unsigned DSSS_ONES = 4,
    parameter int unsigned RLSS_ONES = 2,
    parameter int unsigned CONSUME   = 1
) (
    input logic                         clk,
    input logic                         rst,
    spare_validity_checker_seq_if.slave bus
);
    localparam int unsigned IDX_W = (N_PIVOT > 1) ? $clog2(N_PIVOT) : 1;
    localparam int unsigned CNT_W = $clog2(N_PIVOT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_SCAN,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [1:0]                 mode_q, mode_d;
    logic [DSSS_W-1:0]          dsss_q, dsss_d;
    logic [RLSS_W-1:0]          rlss_q, rlss_d;
    logic [N_PIVOT-1:0][1:0]    bank_q, bank_d;
    logic [N_PIVOT-1:0][2:0]    flag_q, flag_d;
    logic                       pop_ok_q, pop_ok_d;
    logic                       mode_ok_q, mode_ok_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       valid_q, valid_d;
    logic [7:0]                 unused_q, unused_d;
    logic [N_PIVOT-1:0]         uncover_q, uncover_d;
    logic [CNT_W-1:0]           ucnt_q, ucnt_d;

    logic [2:0]                 cur_flag;
    logic                       cur_bank1;
    logic                       cur_one_hot;
    logic [7:0]                 hits;
    logic [7:0]                 low_bit;

    // Spare-coverage mask for a one-hot must flag; table packed as {row, col, adj}.
    function automatic logic [7:0] spare_mask(input logic [1:0] m, input logic b1,
                                              input logic [2:0] f);
        logic [23:0] tab;
        logic [7:0]  sel;
        case ({m, b1})
            3'b010:  tab = 24'hA0_0A_50;
            3'b011:  tab = 24'h50_05_A0;
            3'b100:  tab = 24'hA0_0B_50;
            3'b101:  tab = 24'h50_07_A0;
            3'b110:  tab = 24'hB0_0B_70;
            3'b111:  tab = 24'h70_07_B0;
            default: tab = 24'h0;
        endcase
        case (f)
            3'b100:  sel = tab[23:16];
            3'b010:  sel = tab[15:8];
            3'b001:  sel = tab[7:0];
            default: sel = 8'h00;
        endcase
        return sel;
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        dsss_d      = dsss_q;
        rlss_d      = rlss_q;
        bank_d      = bank_q;
        flag_d      = flag_q;
        pop_ok_d    = pop_ok_q;
        mode_ok_d   = mode_ok_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        valid_d     = valid_q;
        unused_d    = unused_q;
        uncover_d   = uncover_q;
        ucnt_d      = ucnt_q;

        cur_flag    = flag_q[idx_q];
        cur_bank1   = (bank_q[idx_q] != 2'b01);
        cur_one_hot = (cur_flag == 3'b100) || (cur_flag == 3'b010) || (cur_flag == 3'b001);
        hits        = spare_mask(mode_q, cur_bank1, cur_flag) & unused_q;
        low_bit     = hits & (~hits + 8'd1);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_COUNT;
                    idx_d     = '0;
                    mode_d    = bus.mode;
                    dsss_d    = bus.DSSS;
                    rlss_d    = bus.RLSS;
                    bank_d    = bus.bank_addr;
                    flag_d    = bus.must_flag;
                    unused_d  = bus.spare_avail;
                    uncover_d = '0;
                    ucnt_d    = '0;
                    valid_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_COUNT: begin
                pop_ok_d  = ($countones(dsss_q) == int'(DSSS_ONES)) &&
                            ($countones(rlss_q) == int'(RLSS_ONES));
                mode_ok_d = (mode_q != 2'd0);
                state_d   = S_SCAN;
            end
            S_SCAN: begin
                // Flagged pivot is uncovered on bad flag, illegal mode or no free spare.
                if (cur_flag != 3'b000) begin
                    if (!cur_one_hot || !mode_ok_q || (hits == 8'h00)) begin
                        uncover_d[idx_q] = 1'b1;
                        ucnt_d           = ucnt_q + CNT_W'(1);
                    end else if (CONSUME != 0) begin
                        unused_d = unused_q & ~low_bit;
                    end
                end
                if (idx_q == IDX_W'(N_PIVOT - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    valid_d = pop_ok_q && mode_ok_q && (ucnt_d == '0);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            mode_q    <= '0;
            dsss_q    <= '0;
            rlss_q    <= '0;
            bank_q    <= '0;
            flag_q    <= '0;
            pop_ok_q  <= 1'b0;
            mode_ok_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            unused_q  <= 8'hFF;
            uncover_q <= '0;
            ucnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            dsss_q    <= dsss_d;
            rlss_q    <= rlss_d;
            bank_q    <= bank_d;
            flag_q    <= flag_d;
            pop_ok_q  <= pop_ok_d;
            mode_ok_q <= mode_ok_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            unused_q  <= unused_d;
            uncover_q <= uncover_d;
            ucnt_q    <= ucnt_d;
        end
    end

    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
    assign bus.signal_valid       = valid_q;
    assign bus.unused_spare       = unused_q;
    assign bus.uncover_must_pivot = uncover_q;
    assign bus.uncover_count      = ucnt_q;

endmodule
